// File: rtl/c_bus_pkg.sv
// Shared constants for the c_bus control PIO: word field positions, command width, FSM encoding.
// Holds no logic of its own. The only helper packs a command into a 32-bit PIO word.
package c_bus_pkg;

  localparam int CB_STB     = 27;
  localparam int CB_TGT_HI  = 26;
  localparam int CB_TGT_LO  = 24;
  localparam int CB_ADDR_HI = 23;
  localparam int CB_ADDR_LO = 16;
  localparam int CB_DATA_HI = 15;
  localparam int CB_DATA_LO = 0;
  localparam int CB_CMD_W   = 27;

  localparam logic [3:0] S_INIT       = 4'd0;
  localparam logic [3:0] S_IDLE       = 4'd1;
  localparam logic [3:0] S_SETUP_WR   = 4'd2;
  localparam logic [3:0] S_SETUP_WAIT = 4'd3;
  localparam logic [3:0] S_STB_WR     = 4'd4;
  localparam logic [3:0] S_STB_WAIT   = 4'd5;
  localparam logic [3:0] S_REL_WR     = 4'd6;
  localparam logic [3:0] S_REL_WAIT   = 4'd7;
  localparam logic [3:0] S_ACK        = 4'd8;

  // cmd layout is {target[2:0], addr[7:0], data[15:0]}; bits 31:28 of the PIO word stay 0.
  function automatic logic [31:0] cb_word(input logic stb, input logic [CB_CMD_W-1:0] cmd);
    logic [31:0] w;
    w = '0;
    w[CB_STB]                = stb;
    w[CB_TGT_HI:CB_TGT_LO]   = cmd[26:24];
    w[CB_ADDR_HI:CB_ADDR_LO] = cmd[23:16];
    w[CB_DATA_HI:CB_DATA_LO] = cmd[15:0];
    return w;
  endfunction

endpackage

// File: rtl/c_bus_rr_arbiter.sv
// Round-robin arbiter: grant goes to the first requester after the pointer, wrapping around.
// Grant and index are combinational. The pointer moves to the winner only when advance_i is high.
module c_bus_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [2:0]         grant_idx_o
);

  logic [2:0] ptr_q;
  logic [7:0] req_w;
  logic [3:0] cand;
  logic       found;

  always_comb begin
    req_w       = 8'(req_i);
    found       = 1'b0;
    grant_idx_o = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 4'(ptr_q) + 4'(k);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!found && req_w[cand[2:0]]) begin
        found       = 1'b1;
        grant_idx_o = cand[2:0];
      end
    end
  end

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < NUM_REQ; i++)
      grant_o[i] = found && (grant_idx_o == 3'(i));
  end

  // Starting at NUM_REQ-1 makes requester 0 the first winner after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 3'(NUM_REQ - 1);
    else if (advance_i && found) ptr_q <= grant_idx_o;
  end

endmodule

// File: rtl/c_bus_sequencer.sv
// Sole Avalon-MM master of the c_bus PIO: arbitrates requesters and issues setup/strobe/release writes.
// Latency: req seen in IDLE -> ack after 4+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles. Requesters hold req until ack.
module c_bus_sequencer
  import c_bus_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*CB_CMD_W-1:0] cmd,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        busy,
  output logic [2:0]                  grant_id,
  output logic [1:0]                  avm_address,
  output logic                        avm_chipselect,
  output logic                        avm_write_n,
  output logic [31:0]                 avm_writedata
);

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC);

  logic [3:0]          state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [CB_CMD_W-1:0] cmd_q, cmd_d, cmd_sel;
  logic [2:0]          gid_q, gid_d;
  logic                wr_q, wr_d;
  logic [31:0]         wdat_q, wdat_d;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [2:0]          arb_idx;
  logic                arb_adv;

  assign arb_adv = (state_q == S_IDLE) && (|req);

  c_bus_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req),
    .advance_i  (arb_adv),
    .grant_o    (arb_gnt),
    .grant_idx_o(arb_idx)
  );

  always_comb begin
    cmd_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (arb_gnt[i]) cmd_sel = cmd[i*CB_CMD_W +: CB_CMD_W];
  end

  // The PIO word is registered one state ahead, so each write shows up during its *_WR state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    gid_d   = gid_q;
    wr_d    = 1'b0;
    wdat_d  = wdat_q;
    case (state_q)
      S_INIT: begin
        state_d = S_IDLE;
        wr_d    = 1'b1;
        wdat_d  = '0;
      end
      S_IDLE: begin
        if (|req) begin
          state_d = S_SETUP_WR;
          cmd_d   = cmd_sel;
          gid_d   = arb_idx;
          wr_d    = 1'b1;
          wdat_d  = cb_word(1'b0, cmd_sel);
        end
      end
      S_SETUP_WR: begin
        if (SETUP_LD == 8'd0) begin
          state_d = S_STB_WR;
          wr_d    = 1'b1;
          wdat_d  = cb_word(1'b1, cmd_q);
        end else begin
          state_d = S_SETUP_WAIT;
          cnt_d   = SETUP_LD;
        end
      end
      S_SETUP_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = S_STB_WR;
          wr_d    = 1'b1;
          wdat_d  = cb_word(1'b1, cmd_q);
        end
      end
      S_STB_WR: begin
        if (STROBE_LD == 8'd0) begin
          state_d = S_REL_WR;
          wr_d    = 1'b1;
          wdat_d  = cb_word(1'b0, cmd_q);
        end else begin
          state_d = S_STB_WAIT;
          cnt_d   = STROBE_LD;
        end
      end
      S_STB_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = S_REL_WR;
          wr_d    = 1'b1;
          wdat_d  = cb_word(1'b0, cmd_q);
        end
      end
      S_REL_WR: begin
        if (HOLD_LD == 8'd0) begin
          state_d = S_ACK;
        end else begin
          state_d = S_REL_WAIT;
          cnt_d   = HOLD_LD;
        end
      end
      S_REL_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      cmd_q   <= '0;
      gid_q   <= '0;
      wr_q    <= 1'b0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      gid_q   <= gid_d;
      wr_q    <= wr_d;
      wdat_q  <= wdat_d;
    end
  end

  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_REQ; i++)
      ack[i] = (state_q == S_ACK) && (gid_q == 3'(i));
  end

  assign busy           = (state_q != S_IDLE);
  assign grant_id       = gid_q;
  assign avm_address    = 2'b00;
  assign avm_chipselect = wr_q;
  assign avm_write_n    = ~wr_q;
  assign avm_writedata  = wdat_q;

endmodule

// File: tb/tb_c_bus_sequencer.sv
// Scoreboard bench for c_bus_sequencer: default-parameter instance plus a SETUP=0/STROBE=1/HOLD=0 instance.
module tb_c_bus_sequencer;

  typedef struct { logic [31:0] dat; int cyc; } wr_t;
  typedef struct { logic [1:0] a; logic [2:0] gid; int cyc; } ak_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, rst2 = 1'b1;
  logic [1:0]  req = '0, req2 = '0;
  logic [53:0] cmd = '0, cmd2 = '0;

  logic [1:0]  ack, ack2, addr, addr2;
  logic        busy, busy2, cs, cs2, wn, wn2;
  logic [2:0]  gid, gid2;
  logic [31:0] wd, wd2;

  c_bus_sequencer dut (
    .clk(clk), .reset(reset), .req(req), .cmd(cmd), .ack(ack), .busy(busy), .grant_id(gid),
    .avm_address(addr), .avm_chipselect(cs), .avm_write_n(wn), .avm_writedata(wd)
  );

  c_bus_sequencer #(.NUM_REQ(2), .SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0)) dut2 (
    .clk(clk), .reset(rst2), .req(req2), .cmd(cmd2), .ack(ack2), .busy(busy2), .grant_id(gid2),
    .avm_address(addr2), .avm_chipselect(cs2), .avm_write_n(wn2), .avm_writedata(wd2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  wr_t wq[$], wq2[$];
  ak_t aq[$], aq2[$];
  int  n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  task automatic push_wr(input bit d2, input int c, input logic [31:0] w);
    wr_t e;
    e.dat = w;
    e.cyc = c;
    if (d2) wq2.push_back(e); else wq.push_back(e);
  endtask

  task automatic push_txn(input bit d2, input int c0, input int t1, input int t2, input int t3,
                          input int ta, input logic [31:0] w_lo, input logic [31:0] w_hi,
                          input logic [1:0] a, input logic [2:0] g);
    ak_t k;
    push_wr(d2, c0 + t1, w_lo);
    push_wr(d2, c0 + t2, w_hi);
    push_wr(d2, c0 + t3, w_lo);
    k.a = a;
    k.gid = g;
    k.cyc = c0 + ta;
    if (d2) aq2.push_back(k); else aq.push_back(k);
  endtask

  // Monitor for the default instance.
  always @(negedge clk) begin
    if (!reset) begin
      if (cs || !wn) begin
        if (wq.size() == 0) flag("unexpected_write");
        else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_data", wd, e.dat);
          chk("wr_cyc", 32'(cyc), 32'(e.cyc));
          chk("wr_strobe_pair", 32'({cs, wn}), 32'h2);
          chk("wr_addr", 32'(addr), 32'h0);
        end
      end
      if (ack != 2'b00) begin
        if (aq.size() == 0) flag("unexpected_ack");
        else begin
          ak_t k;
          k = aq.pop_front();
          chk("ack_val", 32'(ack), 32'(k.a));
          chk("ack_cyc", 32'(cyc), 32'(k.cyc));
          chk("ack_gid", 32'(gid), 32'(k.gid));
        end
      end
    end
  end

  // Monitor for the short-timing instance.
  always @(negedge clk) begin
    if (!rst2) begin
      if (cs2 || !wn2) begin
        if (wq2.size() == 0) flag("unexpected_write2");
        else begin
          wr_t e;
          e = wq2.pop_front();
          chk("wr2_data", wd2, e.dat);
          chk("wr2_cyc", 32'(cyc), 32'(e.cyc));
          chk("wr2_strobe_pair", 32'({cs2, wn2}), 32'h2);
        end
      end
      if (ack2 != 2'b00) begin
        if (aq2.size() == 0) flag("unexpected_ack2");
        else begin
          ak_t k;
          k = aq2.pop_front();
          chk("ack2_val", 32'(ack2), 32'(k.a));
          chk("ack2_cyc", 32'(cyc), 32'(k.cyc));
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while ((wq.size() + aq.size() + wq2.size() + aq2.size()) != 0 && n < lim) begin
      step();
      n++;
    end
    if ((wq.size() + aq.size() + wq2.size() + aq2.size()) != 0) begin
      flag("drain_timeout");
      wq.delete(); aq.delete(); wq2.delete(); aq2.delete();
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_cs", 32'(cs), 32'h0);
    chk("rst_write_n", 32'(wn), 32'h1);
    chk("rst_wdata", wd, 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_gid", 32'(gid), 32'h0);
  endtask

  initial begin
    int c0;
    // Reset values, then the single INIT clear write on both instances.
    repeat (3) step();
    chk_reset_vals();
    chk("rst_addr", 32'(addr), 32'h0);
    c0 = cyc;
    reset = 1'b0;
    rst2  = 1'b0;
    push_wr(1'b0, c0 + 1, 32'h0);
    push_wr(1'b1, c0 + 1, 32'h0);
    repeat (6) step();
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_busy2", 32'(busy2), 32'h0);
    chk("init_writes_seen", 32'(wq.size() + wq2.size()), 32'h0);

    // Single transaction from requester 0.
    c0 = cyc;
    cmd[26:0] = 27'h5A41234;
    req = 2'b01;
    push_txn(1'b0, c0, 1, 4, 9, 12, 32'h05A41234, 32'h0DA41234, 2'b01, 3'd0);
    step();
    chk("busy_after_grant", 32'(busy), 32'h1);
    run_until(c0 + 12);
    req = 2'b00;
    drain(40);

    // Fresh reset, then both requesters held: grants alternate 0,1,0,1.
    reset = 1'b1;
    step();
    c0 = cyc;
    reset = 1'b0;
    push_wr(1'b0, c0 + 1, 32'h0);
    repeat (3) step();
    c0 = cyc;
    cmd[53:27] = 27'h23CBEEF;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0)
        push_txn(1'b0, c0 + 13 * k, 1, 4, 9, 12, 32'h05A41234, 32'h0DA41234, 2'b01, 3'd0);
      else
        push_txn(1'b0, c0 + 13 * k, 1, 4, 9, 12, 32'h023CBEEF, 32'h0A3CBEEF, 2'b10, 3'd1);
    end
    run_until(c0 + 51);
    req = 2'b00;
    drain(40);

    // Reset during STB_WAIT: strobe write seen, no release write, no ack.
    step();
    c0 = cyc;
    req = 2'b01;
    push_wr(1'b0, c0 + 1, 32'h05A41234);
    push_wr(1'b0, c0 + 4, 32'h0DA41234);
    run_until(c0 + 6);
    #1;
    reset = 1'b1;
    #1;
    chk_reset_vals();
    req = 2'b00;
    step();
    step();
    c0 = cyc;
    reset = 1'b0;
    push_wr(1'b0, c0 + 1, 32'h0);
    repeat (4) step();
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_strobe_cleared", wd, 32'h0);
    drain(10);

    // cmd changed and req dropped right after grant: latched command is used throughout.
    c0 = cyc;
    cmd[26:0] = 27'h5A41234;
    req = 2'b01;
    push_txn(1'b0, c0, 1, 4, 9, 12, 32'h05A41234, 32'h0DA41234, 2'b01, 3'd0);
    step();
    cmd[26:0] = 27'h7FFFFFF;
    req = 2'b00;
    drain(40);
    step();
    chk("latched_busy_end", 32'(busy), 32'h0);

    // Short-timing instance: writes at +1, +2, +4, ack at +5.
    c0 = cyc;
    cmd2[26:0] = 27'h755A5A5;
    req2 = 2'b01;
    push_txn(1'b1, c0, 1, 2, 4, 5, 32'h0755A5A5, 32'h0F55A5A5, 2'b01, 3'd0);
    run_until(c0 + 5);
    req2 = 2'b00;
    drain(20);

    repeat (3) step();
    chk("final_queues_empty", 32'(wq.size() + aq.size() + wq2.size() + aq2.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/c_bus_sequencer.md
Name: c_bus_sequencer

Overview:
Avalon-MM master that owns the 28-bit control bus PIO (c_bus). It shares that PIO between NUM_REQ requesters (one per core in the 2x2 array) using a round-robin arbiter. Each granted command is issued as a three-phase write sequence: setup with the strobe low, strobe high, then release. Requesters never touch the PIO directly; the sequencer is the only Avalon master on that slave.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
SETUP_CYC, 2, idle cycles after the setup write, before the strobe write (0..255)
STROBE_CYC, 4, idle cycles the strobe is held high after the strobe write (0..255)
HOLD_CYC, 2, idle cycles after the release write, before ack (0..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester request level
cmd  in  NUM_REQ*27  per-requester command; slice i = cmd[27*i+26:27*i] = {target[2:0], addr[7:0], data[15:0]}
ack  out  NUM_REQ  one-hot, one-cycle completion pulse
busy  out  1  high whenever the FSM is not in IDLE
grant_id  out  3  index of the requester currently being served (valid while busy)
avm_address  out  2  PIO register address; always 0
avm_chipselect  out  1  PIO chipselect
avm_write_n  out  1  PIO write strobe, active-low
avm_writedata  out  32  PIO write data

Behaviour:
- c_bus word layout: bit27 = strobe, [26:24] = target, [23:16] = addr, [15:0] = data. writedata[31:28] is always 0.
- Reset (async) values:
  - avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
  - ack=0, busy=1, grant_id=0.
  - RR pointer = NUM_REQ-1, so requester 0 wins first. FSM = INIT.
- INIT: for one cycle, write 0x0000_0000 to the PIO (drives strobe low after any reset), then go to IDLE. busy=0 only once in IDLE.
- PIO write cycle: chipselect=1, write_n=0 for exactly one cycle; otherwise chipselect=0, write_n=1. The PIO has no waitrequest.
- FSM states: INIT, IDLE, SETUP_WR, SETUP_WAIT, STB_WR, STB_WAIT, REL_WR, REL_WAIT, ACK.
- IDLE with any req high:
  - grant the first requester after the RR pointer (wrapping); latch its cmd and grant_id; update the pointer.
  - go to SETUP_WR.
- SETUP_WR: write {0, cmd}, load the counter with SETUP_CYC, then go to SETUP_WAIT.
- STB_WR: write {1, cmd}, load STROBE_CYC, then go to STB_WAIT.
- REL_WR: write {0, cmd}, load HOLD_CYC, then go to REL_WAIT.
- Each *_WAIT state decrements the counter and exits when it reaches 0. A parameter value of 0 skips the WAIT state entirely.
- ACK: ack[grant_id]=1 for one cycle, then IDLE.
- Latency: req sampled in IDLE at cycle 0 → ack at cycle 4+SETUP_CYC+STROBE_CYC+HOLD_CYC (12 with defaults).
- The latched cmd is used for the whole sequence. cmd changes after grant are ignored.
- Requester contract: hold req and cmd until ack, and deassert req the cycle after ack or present a new command. If req drops mid-sequence, the sequence still completes and ack still pulses.
- IDLE back-to-back: the minimum gap between transactions is 1 IDLE cycle. A requester still asserting req after its ack gets re-served only after the other pending requesters.
- Simultaneous requests are served in round-robin order. No requester waits more than NUM_REQ-1 transactions.
- Asserting reset mid-sequence aborts immediately with no ack. After release, INIT clears the PIO, including a strobe left high.
- Counter width is 8 bits; no wrap beyond 255.

Decomposition:
- Package c_bus_pkg holds:
  - field positions CB_STB=27, CB_TGT_HI/LO=26/24, CB_ADDR_HI/LO=23/16, CB_DATA_HI/LO=15/0
  - CB_CMD_W=27
  - the state encoding constants
- One sub-module, c_bus_rr_arbiter (NUM_REQ): inputs req, pointer, advance; outputs one-hot grant and encoded index. Purely combinational except for the pointer register.

Test Plan:
- Reset released, no req → exactly one PIO write of 0x00000000 in the cycle after INIT, then busy=0 and no further writes.
- req[0], cmd = {3'd5, 8'hA4, 16'h1234} → writes 0x05A41234, 0x0DA41234, 0x05A41234 at cycles 1/4/9 after grant; ack[0] at cycle 12.
- req[0] and req[1] held continuously → grants alternate 0,1,0,1. Each ack is one-hot and one cycle wide.
- Parameters SETUP_CYC=0, STROBE_CYC=1, HOLD_CYC=0 → writes on consecutive cycles 1, 2, then 4; ack at cycle 5.
- Reset asserted during STB_WAIT → outputs return to reset values asynchronously with no ack. After release, the INIT write of 0 clears the strobe.
- cmd changed and req[0] dropped after grant → all three writes carry the originally latched cmd, and ack[0] still pulses.
